input_fifo: RTL and testbench

Per-port input buffer of the NoC router, sitting directly upstream of each output-port arbiter. It accepts flits from the neighbouring router or local core over the RTS/CTS link handshake and stores them in a small circular buffer. It presents the head flit to the crossbar and pops it when any downstream arbiter grants this input. Its `CTS` pairs with the upstream sender's `RTS`/`DCTS` logic, and its read enables are driven by the arbiters' `Grant_*` outputs.

---
 rtl/router_pkg.sv | 31 +++
 rtl/fifo_storage.sv | 43 ++++
 rtl/input_fifo.sv | 105 ++++++++++
 tb/tb_input_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg
// Shared definitions for the NoC router slice.
//   - DEFAULT_DATA_WIDTH : flit width used when a block is not overridden.
//   - port_idx_t         : output-port index, same bit order as the arbiter's
//                          Xbar_sel vector (L=4, S=3, W=2, E=1, N=0).
//   - SEL_*              : one-hot versions of the port indices.
//   - port_onehot()      : converts a port index to its one-hot select.
package router_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int NUM_PORTS          = 5;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_W = 3'd2,
    PORT_S = 3'd3,
    PORT_L = 3'd4
  } port_idx_t;

  localparam logic [NUM_PORTS-1:0] SEL_N = 5'b00001;
  localparam logic [NUM_PORTS-1:0] SEL_E = 5'b00010;
  localparam logic [NUM_PORTS-1:0] SEL_W = 5'b00100;
  localparam logic [NUM_PORTS-1:0] SEL_S = 5'b01000;
  localparam logic [NUM_PORTS-1:0] SEL_L = 5'b10000;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t p);
    return SEL_N << p;
  endfunction

endpackage

// File: rtl/fifo_storage.sv
// fifo_storage
// Flit register array for the input FIFO: one synchronous write port and one
// asynchronous read port. A synchronous reset clears every slot so that the
// read port shows zero straight after reset.
//   clk      in   clock
//   rst      in   synchronous active-high reset, clears all slots
//   wr_en    in   write strobe
//   wr_addr  in   write slot index
//   wr_data  in   flit to store
//   rd_addr  in   read slot index
//   rd_data  out  flit at rd_addr (combinational)
import router_pkg::*;

module fifo_storage #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Reset wins over a write so a flit presented in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/input_fifo.sv
// input_fifo
// Per-port input buffer of the NoC router. Flits arrive over the RTS/CTS link
// handshake and are kept in a small circular buffer; the head flit is shown to
// the crossbar and popped when any output arbiter grants this input.
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   RX         in   incoming flit, valid while DRTS is high
//   DRTS       in   upstream request-to-send
//   read_en_N/E/W/S/L  in  pop requests from the five output arbiters
//   CTS        out  registered clear-to-send, one-cycle pulse per accepted flit
//   Data_out   out  head flit (combinational from storage at rd_ptr)
//   empty      out  occupancy is zero
//   full       out  occupancy equals DEPTH
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
import router_pkg::*;

module input_fifo #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic                  CTS,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;
  logic                 cts_ff;
  logic                 cts_in;
  logic                 write_en;
  logic                 read_en;
  logic [NUM_PORTS-1:0] read_req;

  assign read_req[PORT_N] = read_en_N;
  assign read_req[PORT_E] = read_en_E;
  assign read_req[PORT_W] = read_en_W;
  assign read_req[PORT_S] = read_en_S;
  assign read_req[PORT_L] = read_en_L;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A flit is accepted only when no acknowledge is in flight; this keeps CTS
  // from ever being high two cycles running. full comes from the registered
  // count, so a pop in the same cycle cannot open the door for a write.
  assign cts_in   = ~cts_ff & DRTS & ~full;
  assign write_en = DRTS & cts_in;

  // Several grants at once are illegal but collapse to a single pop.
  assign read_en = (|read_req) & ~empty;

  assign CTS = cts_ff;

  // Handshake register, pointers and occupancy. Pointers are log2(DEPTH)
  // wide so they wrap from DEPTH-1 to 0 without extra logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      cts_ff <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      cts_ff <= cts_in;
      if (write_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (read_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (write_en && !read_en) begin
        count <= count + 1'b1;
      end else if (read_en && !write_en) begin
        count <= count - 1'b1;
      end
    end
  end

  fifo_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (write_en),
    .wr_addr (wr_ptr),
    .wr_data (RX),
    .rd_addr (rd_ptr),
    .rd_data (Data_out)
  );

endmodule

// File: tb/tb_input_fifo.sv
// tb_input_fifo
// Self-checking bench for input_fifo. A queue-based reference model applies
// the buffer rules at flit level (accept when idle, requested and not full;
// pop when requested and not empty) and each scenario task compares the DUT
// ports against it or against fixed expected values.
module tb_input_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] RX;
  logic          DRTS;
  logic          read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic          CTS;
  logic [DW-1:0] Data_out;
  logic          empty;
  logic          full;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: stored flits in order and whether an acknowledge
  // was issued in the previous cycle.
  logic [DW-1:0] q[$];
  bit            m_cts = 1'b0;

  always #5 clk = ~clk;

  input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .DRTS      (DRTS),
    .read_en_N (read_en_N),
    .read_en_E (read_en_E),
    .read_en_W (read_en_W),
    .read_en_S (read_en_S),
    .read_en_L (read_en_L),
    .CTS       (CTS),
    .Data_out  (Data_out),
    .empty     (empty),
    .full      (full)
  );

  // Drives one cycle of inputs, advances the model at the clock edge and
  // returns 1 ns after the edge so outputs can be sampled.
  task automatic step(input bit r, input bit drts, input logic [DW-1:0] rx,
                      input logic [4:0] rd);
    bit acc;
    bit pop;
    rst  = r;
    DRTS = drts;
    RX   = rx;
    {read_en_L, read_en_S, read_en_W, read_en_E, read_en_N} = rd;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_cts = 1'b0;
    end else begin
      acc = drts && !m_cts && (q.size() < DEPTH);
      pop = (rd != 5'b0) && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(rx);
      m_cts = acc;
    end
    #1;
  endtask

  // Holds DRTS with a flit until CTS is seen (bounded), no pops.
  task automatic send_flit(input logic [DW-1:0] d, output bit acked);
    acked = 1'b0;
    for (int i = 0; i < 8 && !acked; i++) begin
      step(1'b0, 1'b1, d, 5'b0);
      if (CTS === 1'b1) acked = 1'b1;
    end
  endtask

  function automatic logic [4:0] rand_port();
    return 5'b00001 << $urandom_range(0, 4);
  endfunction

  task automatic test_reset();
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 5'b0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 5'b0);
    n_cmp++; if (CTS !== 1'b0) begin n_err++; $display("[TB] FAIL reset_cts: got %b want 0", CTS); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("[TB] FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("[TB] FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (Data_out !== 32'h0) begin n_err++; $display("[TB] FAIL reset_data: got %h want 0", Data_out); end
    step(1'b0, 1'b1, 32'h0000_00C1, 5'b0);
    n_cmp++; if (CTS !== 1'b1) begin n_err++; $display("[TB] FAIL reset_first_cts: got %b want 1", CTS); end
    step(1'b0, 1'b0, 32'h0, 5'b0);
    n_cmp++; if (CTS !== 1'b0) begin n_err++; $display("[TB] FAIL reset_cts_drop: got %b want 0", CTS); end
    n_cmp++; if (Data_out !== 32'h0000_00C1) begin n_err++; $display("[TB] FAIL reset_first_flit: got %h want 000000c1", Data_out); end
    step(1'b0, 1'b0, 32'h0, 5'b00001);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("[TB] FAIL reset_drain: got %b want 1", empty); end
  endtask

  task automatic test_single_flit();
    int  pulses = 0;
    bit  seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step(1'b0, 1'b1, 32'hA5A5_0001, 5'b0);
      if (CTS === 1'b1) begin seen = 1'b1; pulses++; end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 5'b0);
      if (CTS === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("[TB] FAIL single_pulses: got %0d want 1", pulses); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("[TB] FAIL single_empty: got %b want 0", empty); end
    n_cmp++; if (Data_out !== 32'hA5A5_0001) begin n_err++; $display("[TB] FAIL single_data: got %h want a5a50001", Data_out); end
    step(1'b0, 1'b0, 32'h0, 5'b00010);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("[TB] FAIL single_pop: got %b want 1", empty); end
  endtask

  task automatic test_fill();
    bit ack;
    for (int i = 0; i < 4; i++) begin
      send_flit(32'h10 + i, ack);
      n_cmp++; if (ack !== 1'b1) begin n_err++; $display("[TB] FAIL fill_ack%0d: got %b want 1", i, ack); end
    end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("[TB] FAIL fill_full: got %b want 1", full); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'h14, 5'b0);
      n_cmp++; if (CTS !== 1'b0) begin n_err++; $display("[TB] FAIL fill_blocked%0d: got %b want 0", i, CTS); end
    end
    step(1'b0, 1'b1, 32'h14, 5'b00001);
    n_cmp++; if (CTS !== 1'b0) begin n_err++; $display("[TB] FAIL fill_pop_cycle_cts: got %b want 0", CTS); end
    n_cmp++; if (Data_out !== 32'h11) begin n_err++; $display("[TB] FAIL fill_pop_head: got %h want 11", Data_out); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("[TB] FAIL fill_pop_full: got %b want 0", full); end
    step(1'b0, 1'b1, 32'h14, 5'b0);
    n_cmp++; if (CTS !== 1'b1) begin n_err++; $display("[TB] FAIL fill_resume_cts: got %b want 1", CTS); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (Data_out !== 32'h11 + k) begin n_err++; $display("[TB] FAIL fill_drain%0d: got %h want %h", k, Data_out, 32'h11 + k); end
      step(1'b0, 1'b0, 32'h0, rand_port());
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("[TB] FAIL fill_empty: got %b want 1", empty); end
  endtask

  task automatic test_wrap_order();
    logic [DW-1:0] next_in = 32'h20;
    int            popped = 0;
    bit            pre_empty;
    logic [DW-1:0] pre_data;
    logic [4:0]    rd;
    bit            drts;
    for (int cyc = 0; cyc < 300 && popped < 10; cyc++) begin
      drts = (next_in <= 32'h29);
      rd   = ($urandom_range(0, 2) == 0) ? rand_port() : 5'b0;
      pre_empty = empty;
      pre_data  = Data_out;
      step(1'b0, drts, next_in, rd);
      if (drts && CTS === 1'b1) next_in++;
      if (rd != 5'b0 && !pre_empty) begin
        n_cmp++; if (pre_data !== 32'h20 + popped) begin n_err++; $display("[TB] FAIL wrap_order%0d: got %h want %h", popped, pre_data, 32'h20 + popped); end
        popped++;
      end
      n_cmp++; if (empty !== (q.size() == 0)) begin n_err++; $display("[TB] FAIL wrap_empty: got %b want %b", empty, q.size() == 0); end
      n_cmp++; if (full !== (q.size() == DEPTH)) begin n_err++; $display("[TB] FAIL wrap_full: got %b want %b", full, q.size() == DEPTH); end
      n_cmp++; if (CTS !== m_cts) begin n_err++; $display("[TB] FAIL wrap_cts: got %b want %b", CTS, m_cts); end
    end
    n_cmp++; if (popped != 10) begin n_err++; $display("[TB] FAIL wrap_count: got %0d want 10", popped); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("[TB] FAIL wrap_final_empty: got %b want 1", empty); end
  endtask

  task automatic test_simultaneous();
    bit ack;
    send_flit(32'h31, ack);
    send_flit(32'h32, ack);
    step(1'b0, 1'b0, 32'h0, 5'b0);
    step(1'b0, 1'b1, 32'h33, 5'b10000);
    n_cmp++; if (CTS !== 1'b1) begin n_err++; $display("[TB] FAIL simul_cts: got %b want 1", CTS); end
    n_cmp++; if (Data_out !== 32'h32) begin n_err++; $display("[TB] FAIL simul_head: got %h want 32", Data_out); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("[TB] FAIL simul_full: got %b want 0", full); end
    step(1'b0, 1'b0, 32'h0, 5'b10000);
    n_cmp++; if (Data_out !== 32'h33) begin n_err++; $display("[TB] FAIL simul_next: got %h want 33", Data_out); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("[TB] FAIL simul_not_empty: got %b want 0", empty); end
    step(1'b0, 1'b0, 32'h0, 5'b10000);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("[TB] FAIL simul_empty: got %b want 1", empty); end
  endtask

  task automatic test_empty_pop_reset();
    bit ack;
    step(1'b0, 1'b0, 32'h0, 5'b01000);
    step(1'b0, 1'b0, 32'h0, 5'b01000);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("[TB] FAIL epop_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("[TB] FAIL epop_full: got %b want 0", full); end
    send_flit(32'h41, ack);
    n_cmp++; if (Data_out !== 32'h41) begin n_err++; $display("[TB] FAIL epop_head: got %h want 41", Data_out); end
    send_flit(32'h42, ack);
    send_flit(32'h43, ack);
    n_cmp++; if (Data_out !== 32'h41) begin n_err++; $display("[TB] FAIL epop_head3: got %h want 41", Data_out); end
    step(1'b1, 1'b1, 32'h44, 5'b0);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("[TB] FAIL mreset_empty: got %b want 1", empty); end
    n_cmp++; if (Data_out !== 32'h0) begin n_err++; $display("[TB] FAIL mreset_data: got %h want 0", Data_out); end
    n_cmp++; if (CTS !== 1'b0) begin n_err++; $display("[TB] FAIL mreset_cts: got %b want 0", CTS); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("[TB] FAIL mreset_full: got %b want 0", full); end
    step(1'b0, 1'b0, 32'h0, 5'b0);
  endtask

  task automatic test_random();
    bit            r;
    bit            drts;
    logic [4:0]    rd;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r    = ($urandom_range(0, 49) == 0);
      drts = ($urandom_range(0, 1) == 1);
      rd   = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
      step(r, drts, $urandom, rd);
      n_cmp++; if (CTS !== m_cts) begin n_err++; $display("[TB] FAIL rand_cts: cyc %0d got %b want %b", cyc, CTS, m_cts); end
      n_cmp++; if (empty !== (q.size() == 0)) begin n_err++; $display("[TB] FAIL rand_empty: cyc %0d got %b want %b", cyc, empty, q.size() == 0); end
      n_cmp++; if (full !== (q.size() == DEPTH)) begin n_err++; $display("[TB] FAIL rand_full: cyc %0d got %b want %b", cyc, full, q.size() == DEPTH); end
      if (q.size() > 0) begin
        n_cmp++; if (Data_out !== q[0]) begin n_err++; $display("[TB] FAIL rand_data: cyc %0d got %h want %h", cyc, Data_out, q[0]); end
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    DRTS = 1'b0;
    RX   = '0;
    {read_en_L, read_en_S, read_en_W, read_en_E, read_en_N} = 5'b0;
    test_reset();
    test_single_flit();
    test_fill();
    test_wrap_order();
    test_simultaneous();
    test_empty_pop_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
